// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package instr_queue_pkg;

    // Width of the instruction and pc fields carried by one queue entry.
    localparam int PKT_XLEN = 32;

    // Instruction word presented to decode when the queue is empty.
    // Decode classifies all-zero as UNKNOWN, so it causes no writes or jumps.
    localparam logic [PKT_XLEN-1:0] EMPTY_INSTR = 32'h00000000;

    // One buffered fetch result.
    typedef struct packed {
        logic [PKT_XLEN-1:0] instr;
        logic [PKT_XLEN-1:0] pc;
    } FetchPacket;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction buffer. Stores {instr, pc} pairs in FIFO order
// and shows the oldest entry to decode (show-ahead). The queue absorbs decode
// stalls, and a flush discards all of its contents.
// Full and empty come from the occupancy counter. The pointers wrap by
// natural overflow.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    FetchPacket      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    FetchPacket      w_head;
    FetchPacket      w_wr_pkt;

    // in_ready depends only on registered occupancy. A pop in the same
    // cycle does not make room for a push into a full queue.
    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);

    // A flush cancels any handshake that happens in the same cycle.
    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    assign w_wr_pkt.instr = in_instr;
    assign w_wr_pkt.pc    = in_pc;
    assign w_head         = r_mem[r_rd_ptr];

    // The head is forced to the benign empty pattern when nothing is buffered.
    assign out_instr = out_valid ? w_head.instr : EMPTY_INSTR;
    assign out_pc    = out_valid ? w_head.pc    : '0;
    assign count     = r_count;

    // Storage write. Contents are not reset because the counter masks stale data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_pkt;
        end
    end

    // Pointer and occupancy control. A flush takes priority over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Occupancy and handshake invariants.
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= FULL_CNT);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == FULL_CNT)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && (r_count == '0)));

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue with a queue-based scoreboard.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [3:0]        count;

    int n_checks;
    int n_errors;

    FetchPacket sb_q[$];
    int         m_cnt;

    instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[15:0], 16'h0093};
    endfunction

    // One cycle: drive at the negedge, check outputs against the model,
    // advance the model on the posedge, and return at the next negedge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic m_push;
        logic m_pop;
        FetchPacket p;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("count", 64'(count), 64'(m_cnt));
        chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
        chk("in_ready", 64'(in_ready), 64'(m_cnt != DEPTH));
        if (m_cnt != 0 && sb_q.size() != 0) begin
            chk("head_instr", 64'(out_instr), 64'(sb_q[0].instr));
            chk("head_pc", 64'(out_pc), 64'(sb_q[0].pc));
        end else begin
            chk("empty_instr", 64'(out_instr), 64'(EMPTY_INSTR));
            chk("empty_pc", 64'(out_pc), 64'h0);
        end
        m_push = iv && (m_cnt != DEPTH) && !fl;
        m_pop  = ordy && (m_cnt != 0) && !fl;
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
            m_cnt = 0;
        end else begin
            if (m_pop) begin
                void'(sb_q.pop_front());
                m_cnt--;
            end
            if (m_push) begin
                p.instr = ins;
                p.pc    = pc;
                sb_q.push_back(p);
                m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc);
        step(1'b1, mk_instr(pc), pc, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) pop_one();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_cnt     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        // Reset held for two cycles, then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);

        // A pop request on an empty queue is ignored.
        pop_one();
        pop_one();

        // Single push, visible on the next cycle, then popped.
        step(1'b1, 32'h00500093, 32'h1000, 1'b0, 1'b0);
        chk("single_instr", 64'(out_instr), 64'h00500093);
        chk("single_pc", 64'(out_pc), 64'h1000);
        chk("single_count", 64'(count), 64'h1);
        pop_one();
        pop_one();

        // Fill to full, offer a ninth entry, then pop 3 and push 3 across the wrap.
        for (int i = 0; i < DEPTH; i++) push(32'(i * 4));
        chk("full_in_ready", 64'(in_ready), 64'h0);
        push(32'h20);
        push(32'h20);
        for (int i = 0; i < 3; i++) pop_one();
        for (int i = 0; i < 3; i++) push(32'h20 + 32'(i * 4));
        chk("wrap_count", 64'(count), 64'h8);
        drain();

        // Simultaneous push and pop at occupancy 4.
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4));
        for (int i = 0; i < 10; i++)
            step(1'b1, mk_instr(32'h110 + 32'(i * 4)), 32'h110 + 32'(i * 4), 1'b1, 1'b0);
        chk("pp_count", 64'(count), 64'h4);
        drain();

        // Flush with a push and a pop offered in the same cycle.
        for (int i = 0; i < 5; i++) push(32'h200 + 32'(i * 4));
        step(1'b1, 32'hDEADBEEF, 32'h0BAD, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        pop_one();
        push(32'h300);
        drain();

        // Asynchronous reset between clock edges with six entries buffered.
        for (int i = 0; i < 6; i++) push(32'h400 + 32'(i * 4));
        chk("pre_rst_count", 64'(count), 64'h6);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_out_instr", 64'(out_instr), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h1);
        sb_q.delete();
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pop_one();
        push(32'h500);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
